// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// the md-class mask used by the D-stage stall logic, default busy-cycle
// counts and the control FSM state type.
package md_unit_pkg;

  localparam int MD_OP_W = 3;

  // Operation encodings on mdop; 3'd0 and 3'd7 are no-ops.
  localparam logic [MD_OP_W-1:0] MD_NOP   = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  // One bit per mdop encoding: set for operations the stall logic must
  // hold in D while the unit is occupied (MFHI/MFLO are decoded elsewhere).
  localparam logic [7:0] MD_CLASS_MASK = 8'b0111_1110;

  // Default busy periods.
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_md_class(input logic [MD_OP_W-1:0] op);
    logic [7:0] mask;
    mask = MD_CLASS_MASK;
    return mask[op];
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage to multiply/divide unit bus: start strobe, operation, operands
// and the unit's busy flag plus HI/LO read-back.
interface md_unit_if;
  import md_unit_pkg::*;

  logic               start;
  logic [MD_OP_W-1:0] mdop;
  logic [31:0]        a;
  logic [31:0]        b;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;

  modport master (output start, mdop, a, b, input busy, hi, lo);
  modport slave  (input start, mdop, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit_calc.sv
// Combinational arithmetic for the md unit: signed/unsigned 32x32->64
// multiply and 32-bit divide, packed as {hi, lo}. Keeps the signedness
// handling out of the control FSM.
module md_unit_calc
  import md_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0] mdop,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [63:0]        result,
  output logic               div_by_zero
);

  logic        b_zero_s;
  logic        div_ovf_s;
  logic [31:0] b_div_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u_s;
  logic [31:0] rem_u_s;
  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;

  assign b_zero_s  = (b == 32'd0);
  // INT_MIN / -1 overflows a 32-bit quotient; it is forced explicitly below.
  assign div_ovf_s = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  // Divisor substituted with 1 whenever the real one is unusable so the
  // dividers never see zero or the overflow pair; those results are unused.
  assign b_div_s   = (b_zero_s || div_ovf_s) ? 32'd1 : b;

  assign prod_s_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u_s = {32'd0, a} * {32'd0, b};
  assign quo_s    = $signed(a) / $signed(b_div_s);
  assign rem_s    = $signed(a) % $signed(b_div_s);
  assign quo_u_s  = a / b_div_s;
  assign rem_u_s  = a % b_div_s;

  assign div_by_zero = is_div_op(mdop) && b_zero_s;

  // Select the {hi, lo} result for the requested operation.
  always_comb begin
    result = 64'd0;
    case (mdop)
      MD_MULT:  result = prod_s_s;
      MD_MULTU: result = prod_u_s;
      MD_DIV: begin
        if (div_ovf_s) begin
          result = {32'd0, 32'h8000_0000};
        end else begin
          result = {rem_s, quo_s};
        end
      end
      MD_DIVU:  result = {rem_u_s, quo_u_s};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. Owns HI/LO, runs MULT/DIV over a
// fixed number of busy cycles and commits the result only at the end of
// the busy period. MTHI/MTLO write directly while idle.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e   state_r;
  logic [3:0]  count_r;
  logic        busy_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] pend_hi_r;
  logic [31:0] pend_lo_r;
  logic        pend_dz_r;
  logic [63:0] calc_result_s;
  logic        calc_dz_s;

  md_unit_calc u_calc (
    .mdop        (md.mdop),
    .a           (md.a),
    .b           (md.b),
    .result      (calc_result_s),
    .div_by_zero (calc_dz_s)
  );

  assign md.busy = busy_r;
  assign md.hi   = hi_r;
  assign md.lo   = lo_r;

  // Control FSM: capture result at start, count busy cycles, commit at the end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= MD_IDLE;
      count_r   <= 4'd0;
      busy_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_dz_r <= 1'b0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (md.start) begin
            case (md.mdop)
              MD_MULT, MD_MULTU: begin
                pend_hi_r <= calc_result_s[63:32];
                pend_lo_r <= calc_result_s[31:0];
                pend_dz_r <= 1'b0;
                count_r   <= MULT_LOAD;
                busy_r    <= 1'b1;
                state_r   <= MD_BUSY;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi_r <= calc_result_s[63:32];
                pend_lo_r <= calc_result_s[31:0];
                pend_dz_r <= calc_dz_s;
                count_r   <= DIV_LOAD;
                busy_r    <= 1'b1;
                state_r   <= MD_BUSY;
              end
              MD_MTHI: hi_r <= md.a;
              MD_MTLO: lo_r <= md.a;
              default: state_r <= MD_IDLE;
            endcase
          end else begin
            state_r <= MD_IDLE;
          end
        end
        MD_BUSY: begin
          // A start strobe here is a protocol violation and is ignored.
          if (count_r <= 4'd1) begin
            if (!pend_dz_r) begin
              hi_r <= pend_hi_r;
              lo_r <= pend_lo_r;
            end else begin
              hi_r <= hi_r;
              lo_r <= lo_r;
            end
            count_r <= 4'd0;
            busy_r  <= 1'b0;
            state_r <= MD_IDLE;
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        default: begin
          count_r <= 4'd0;
          busy_r  <= 1'b0;
          state_r <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage pipeline.
- Executes MULT/MULTU/DIV/DIVU over a fixed number of cycles and owns the HI/LO registers. Also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.
- It is the producer side of the md stall path. The D-stage stall logic reads start|busy and holds any md-class instruction in D while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (1..15)

Ports:
- clk  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle strobe from E stage: mdop is valid this cycle
- mdop  input  3  operation select; encodings in head.v: MULT, MULTU, DIV, DIVU, MTHI, MTLO (others = no-op)
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- busy  output  1  operation in flight (registered)
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (reset==0, async): busy=0, hi=0, lo=0, cycle counter=0, pending results cleared. Applies immediately at any point, including mid-operation; the in-flight result is discarded.
- IDLE state (busy=0):
  - start with MULT/MULTU/DIV/DIVU: capture the result into pending_hi/pending_lo at the edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to BUSY.
  - busy=1 from the next cycle.
- start with MTHI/MTLO in IDLE: write a into hi or lo at that edge. Visible next cycle; busy stays 0.
- BUSY state:
  - Counter decrements each cycle.
  - On the cycle counter==1, the edge commits pending_hi->hi, pending_lo->lo, clears busy and returns to IDLE.
  - Latency: start at cycle T → busy high for cycles T+1..T+N, new hi/lo and busy=0 visible at T+N+1.
- hi/lo keep their old values throughout BUSY. Results never appear early.
- start while busy=1 is a protocol violation the stall unit prevents. The unit ignores it: no state change, no restart, no HI/LO write.
- Arithmetic:
  - MULT: signed 32x32 → 64, hi=[63:32], lo=[31:0].
  - MULTU: same, unsigned.
  - DIV: lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
  - DIVU: unsigned quotient/remainder.
- DIV with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b==0, DIV or DIVU):
  - Full DIV_CYCLES busy period still runs.
  - HI and LO are left unchanged at commit.
- Operands are sampled only on the start cycle. Later changes on a/b during BUSY have no effect.
- mdop values other than the six defined are no-ops even with start=1.
- Stall contract: the stall unit asserts stall for any md-class instruction (including MFHI/MFLO/MTHI/MTLO) in D when start|busy is 1. The unit does not itself stall anything.

Decomposition:
- head.v holds:
  - the six mdop encodings
  - an md-class opcode mask used by the stall logic
  - default cycle counts as macros
- A single combinational sub-module md_calc is natural. It takes (mdop, a, b) and produces the 64-bit {hi,lo} result plus a div_by_zero flag. It keeps signed/unsigned arithmetic out of the control FSM.
- FSM, counter, HI/LO and pending registers live in md_unit.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7, start at T → busy=1 for T+1..T+5. At T+6: hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy=0.
- MULTU a=0xFFFFFFFF, b=2 → after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. Check hi/lo hold old values at T+3.
- DIV a=0xFFFFFFF9 (-7), b=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0 with prior hi/lo=0x11/0x22 → 10 busy cycles, hi/lo remain 0x11/0x22.
- MTHI a=0xDEADBEEF in IDLE → hi=0xDEADBEEF next cycle, busy never asserts. Then MTLO a=0x1234 → lo=0x1234.
- DIV started at T, second start (MULT) pulsed at T+4 → ignored; commit still at T+11 with DIV result, busy total 10 cycles.
- reset low at T+3 of a MULT → hi=lo=0 and busy=0 immediately (asynchronously). After release, no late commit occurs; a new MULT behaves normally.
